// File: rtl/nibble_serial_subtractor.sv
// Serial N-bit subtractor D = A - B - Bin, one 4-bit lookahead slice per clock, valid/ready on both sides.
// Optional status outputs V (signed overflow) and Z (zero) are enabled by defining SUB_STATUS_FLAGS_EN.
module nibble_serial_subtractor #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         Bout
`ifdef SUB_STATUS_FLAGS_EN
    ,
    output logic         V,
    output logic         Z
`endif
);

    localparam int SLICES = N / 4;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    generate
        if ((N % 4) != 0 || N < 4) begin : g_bad_width
            $error("nibble_serial_subtractor: N must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          borrow;
    logic [CW-1:0] cnt;

    logic [3:0]    a_slice;
    logic [3:0]    b_slice;
    logic [3:0]    g;
    logic [3:0]    p;
    logic [4:0]    c;
    logic [3:0]    diff;
    logic [N-1:0]  d_next;
    logic          last_slice;

`ifdef SUB_STATUS_FLAGS_EN
    logic          v_reg;
    logic          z_reg;
    assign V = v_reg;
    assign Z = z_reg;
`endif

    assign last_slice = (cnt == CW'(SLICES - 1));

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < SLICES; i++) begin
            if (cnt == CW'(i)) begin
                a_slice = a_reg[4*i +: 4];
                b_slice = b_reg[4*i +: 4];
            end
        end
    end

    // Subtraction as A + ~B + ~borrow; carries come from flat generate/propagate terms, no ripple chain.
    always_comb begin
        g    = a_slice & ~b_slice;
        p    = a_slice ^ ~b_slice;
        c[0] = ~borrow;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        diff = p ^ c[3:0];
    end

    always_comb begin
        d_next = D;
        for (int i = 0; i < SLICES; i++) begin
            if (cnt == CW'(i)) begin
                d_next[4*i +: 4] = diff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = CALC;
            CALC:    if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Flags are captured on the same edge as Bout so all result fields change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            Bout   <= 1'b0;
`ifdef SUB_STATUS_FLAGS_EN
            v_reg  <= 1'b0;
            z_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        borrow <= Bin;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    D      <= d_next;
                    borrow <= ~c[4];
                    cnt    <= cnt + CW'(1);
                    if (last_slice) begin
                        Bout  <= ~c[4];
`ifdef SUB_STATUS_FLAGS_EN
                        v_reg <= (a_reg[N-1] != b_reg[N-1]) && (d_next[N-1] != a_reg[N-1]);
                        z_reg <= (d_next == '0);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (N=16): arithmetic reference model plus directed vectors.
// Define SUB_STATUS_FLAGS_EN for both files to exercise the V/Z outputs.
module tb_nibble_serial_subtractor;

    localparam int N = 16;
    localparam int LAT = N / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         Bout;
`ifdef SUB_STATUS_FLAGS_EN
    logic         V;
    logic         Z;
`endif

    int vec_count  = 0;
    int miss_count = 0;

    logic         m_busy   = 1'b0;
    int           m_cycle  = 0;
    int           m_accept = 0;
    logic [N-1:0] m_d      = '0;
    logic         m_bout   = 1'b0;
    logic         m_v      = 1'b0;
    logic         m_z      = 1'b0;
    logic         exp_ov;

    nibble_serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef SUB_STATUS_FLAGS_EN
        ,
        .V         (V),
        .Z         (Z)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a transaction is busy from its accept edge until the result handshake,
    // and its result becomes visible LAT edges after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy && (m_cycle - m_accept >= LAT) && out_ready) begin
                m_busy = 1'b0;
            end else if (!m_busy && in_valid) begin
                m_busy   = 1'b1;
                m_accept = m_cycle + 1;
                {m_bout, m_d} = {1'b0, A} - {1'b0, B} - 17'(Bin);
                m_v = (A[N-1] != B[N-1]) && (m_d[N-1] != A[N-1]);
                m_z = (m_d == '0);
            end
            m_cycle++;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            exp_ov = m_busy && (m_cycle - m_accept >= LAT);
            checkOutput("in_ready", 32'(in_ready), 32'(!m_busy));
            checkOutput("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                checkOutput("D", 32'(D), 32'(m_d));
                checkOutput("Bout", 32'(Bout), 32'(m_bout));
`ifdef SUB_STATUS_FLAGS_EN
                checkOutput("V", 32'(V), 32'(m_v));
                checkOutput("Z", 32'(Z), 32'(m_z));
`endif
            end
        end
    end

    task automatic waitResult(input logic [N-1:0] exp_d, input logic exp_bout);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 32'(n), 32'd4);
        checkOutput("D_lit", 32'(D), 32'(exp_d));
        checkOutput("Bout_lit", 32'(Bout), 32'(exp_bout));
    endtask

    // Returns with the DUT in DONE and the result checked against literal values.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                                 input logic [N-1:0] exp_d, input logic exp_bout);
        int n;
        @(negedge clk);
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        A        = N'($urandom);
        B        = N'($urandom);
        Bin      = 1'($urandom);
        waitResult(exp_d, exp_bout);
    endtask

    task automatic releaseResult(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic checkFlags(input logic exp_v, input logic exp_z);
`ifdef SUB_STATUS_FLAGS_EN
        checkOutput("V_lit", 32'(V), 32'(exp_v));
        checkOutput("Z_lit", 32'(Z), 32'(exp_z));
`else
        if (exp_v === 1'bx || exp_z === 1'bx) $display("[TB] unexpected unknown flag argument");
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_D", 32'(D), 32'd0);
        checkOutput("rst_Bout", 32'(Bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        checkFlags(1'b0, 1'b0);
        releaseResult(0);

        applyStimulus(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        checkFlags(1'b0, 1'b0);
        releaseResult(1);

        applyStimulus(16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0);
        checkFlags(1'b1, 1'b0);
        releaseResult(2);

        applyStimulus(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0);
        checkFlags(1'b0, 1'b0);
        releaseResult(0);

        applyStimulus(16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0);
        checkFlags(1'b0, 1'b1);
        releaseResult(0);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        checkFlags(1'b0, 1'b0);
        releaseResult(3);

        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1);
        checkFlags(1'b1, 1'b0);
        releaseResult(0);

        // Backpressure: new operands are offered throughout CALC and DONE and must wait for IDLE.
        @(negedge clk);
        A        = 16'hC0DE;
        B        = 16'h0ACE;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        A        = 16'h9999;
        B        = 16'h1111;
        waitResult(16'hB610, 1'b0);
        repeat (6) begin
            @(negedge clk);
            checkOutput("bp_D", 32'(D), 32'hB610);
            checkOutput("bp_Bout", 32'(Bout), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_idle_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        waitResult(16'h8888, 1'b0);
        releaseResult(0);

        // Reset two slices into an operation.
        @(negedge clk);
        A        = 16'h1111;
        B        = 16'h2222;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_D", 32'(D), 32'd0);
        checkOutput("mid_rst_Bout", 32'(Bout), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

        applyStimulus(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1);
        checkFlags(1'b0, 1'b0);
        releaseResult(0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
